// File: rtl/da_pkg.sv
// Shared types and defaults for the bit-plane serializer.
package da_pkg;

    localparam int DATA_W_DEF   = 8;
    localparam int KERNEL_H_DEF = 7;

    function automatic int idx_width(input int data_w);
        return (data_w > 1) ? $clog2(data_w) : 1;
    endfunction

    localparam int IDX_W_DEF = idx_width(DATA_W_DEF);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } da_state_e;

endpackage

// File: rtl/da_shift_bank.sv
// KERNEL_H independent DATA_W-bit shift lanes; lsb_bits exposes bit 0 of every lane.
module da_shift_bank
    import da_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int KERNEL_H = KERNEL_H_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         load,
    input  logic                         shift_en,
    input  logic [KERNEL_H*DATA_W-1:0]   load_data,
    output logic [KERNEL_H-1:0]          lsb_bits
);

    logic [KERNEL_H*DATA_W-1:0] lanes_q, lanes_d;

    always_comb begin
        lanes_d = lanes_q;
        if (load) begin
            lanes_d = load_data;
        end else if (shift_en) begin
            for (int k = 0; k < KERNEL_H; k++) begin
                lanes_d[k*DATA_W +: DATA_W] = lanes_q[k*DATA_W +: DATA_W] >> 1;
            end
        end
    end

    always_comb begin
        lsb_bits = '0;
        for (int k = 0; k < KERNEL_H; k++) begin
            lsb_bits[k] = lanes_q[k*DATA_W];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lanes_q <= '0;
        end else begin
            lanes_q <= lanes_d;
        end
    end

endmodule

// File: rtl/da_bitplane_ser.sv
// Serializes a window of KERNEL_H samples into DATA_W bit-planes, LSB plane first.
// Define DA_DOUBLE_BUF_EN to add a one-window shadow buffer for gapless streaming.
module da_bitplane_ser
    import da_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int KERNEL_H = KERNEL_H_DEF
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [KERNEL_H*DATA_W-1:0]      in_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [KERNEL_H-1:0]             out_bits,
    output logic [idx_width(DATA_W)-1:0]    out_idx,
    output logic                            out_first,
    output logic                            out_last
);

    localparam int IDX_W = idx_width(DATA_W);
    localparam int WIN_W = KERNEL_H * DATA_W;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    da_state_e         state_q, state_d;
    logic              out_valid_q, out_valid_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              bank_load, bank_shift;
    logic [WIN_W-1:0]  bank_data;
    logic              in_hs, out_hs, last_hs, is_last;

`ifdef DA_DOUBLE_BUF_EN
    logic              shadow_full_q, shadow_full_d;
    logic [WIN_W-1:0]  shadow_q, shadow_d;

    assign in_ready = !rst && !shadow_full_q;
`else
    assign in_ready = !rst && (state_q == IDLE);
`endif

    assign is_last   = (idx_q == IDX_LAST);
    assign in_hs     = in_valid && in_ready;
    assign out_hs    = out_valid_q && out_ready;
    assign last_hs   = out_hs && is_last;

    assign out_valid = out_valid_q;
    assign out_idx   = idx_q;
    assign out_first = (idx_q == '0);
    assign out_last  = is_last;

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        idx_d       = idx_q;
        bank_load   = 1'b0;
        bank_shift  = 1'b0;
        bank_data   = in_data;
`ifdef DA_DOUBLE_BUF_EN
        shadow_full_d = shadow_full_q;
        shadow_d      = shadow_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_hs) begin
                    bank_load   = 1'b1;
                    idx_d       = '0;
                    state_d     = SHIFT;
                    out_valid_d = 1'b1;
                end
            end
            SHIFT: begin
                if (out_hs && !is_last) begin
                    bank_shift = 1'b1;
                    idx_d      = idx_q + IDX_W'(1);
                end else if (last_hs) begin
                    idx_d = '0;
`ifdef DA_DOUBLE_BUF_EN
                    // Buffered window wins; otherwise a same-cycle input bypasses the shadow.
                    if (shadow_full_q) begin
                        bank_load     = 1'b1;
                        bank_data     = shadow_q;
                        shadow_full_d = 1'b0;
                    end else if (in_hs) begin
                        bank_load = 1'b1;
                    end else begin
                        state_d     = IDLE;
                        out_valid_d = 1'b0;
                    end
`else
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
`endif
                end
`ifdef DA_DOUBLE_BUF_EN
                if (in_hs && !last_hs) begin
                    shadow_d      = in_data;
                    shadow_full_d = 1'b1;
                end
`endif
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            idx_q       <= '0;
`ifdef DA_DOUBLE_BUF_EN
            shadow_full_q <= 1'b0;
            shadow_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            idx_q       <= idx_d;
`ifdef DA_DOUBLE_BUF_EN
            shadow_full_q <= shadow_full_d;
            shadow_q      <= shadow_d;
`endif
        end
    end

    da_shift_bank #(
        .DATA_W   (DATA_W),
        .KERNEL_H (KERNEL_H)
    ) u_bank (
        .clk       (clk),
        .rst       (rst),
        .load      (bank_load),
        .shift_en  (bank_shift),
        .load_data (bank_data),
        .lsb_bits  (out_bits)
    );

endmodule

// File: doc/da_bitplane_ser.md
DA_BITPLANE_SER -- requirements
Module: da_bitplane_ser

Interface
REQ-001 Parameter DATA_W, default 8: sample width in bits, two's complement.
REQ-002 Parameter KERNEL_H, default 7: taps per window; equals the width of one bit-plane.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 in_valid  input  1  window offered.
REQ-006 in_ready  output  1  window accepted when in_valid and in_ready are both high on a clk edge.
REQ-007 in_data  input  KERNEL_H*DATA_W  packed window; tap k occupies bits [k*DATA_W +: DATA_W].
REQ-008 out_valid  output  1  bit-plane present.
REQ-009 out_ready  input  1  bit-plane consumed when out_valid and out_ready are both high.
REQ-010 out_bits  output  KERNEL_H  bit-plane; bit k = bit out_idx of tap k.
REQ-011 out_idx  output  $clog2(DATA_W)  bit position of the current plane, 0..DATA_W-1.
REQ-012 out_first  output  1  high when out_idx == 0.
REQ-013 out_last  output  1  high when out_idx == DATA_W-1 (sign plane, to be subtracted downstream).

Function
REQ-014 The FSM SHALL have two states: IDLE and SHIFT.
REQ-015 In IDLE, out_valid SHALL be 0 and in_ready SHALL be 1.
REQ-016 An input handshake in IDLE SHALL load the working registers and set out_idx=0, and the FSM SHALL enter SHIFT; the first plane is valid the next cycle (latency 1).
REQ-017 Planes SHALL be emitted LSB first, from out_idx 0 to DATA_W-1, one per output handshake.
REQ-018 While out_valid && !out_ready, out_bits, out_idx, out_first and out_last SHALL hold stable.
REQ-019 On an output handshake with !out_last, the working taps SHALL shift right by one and out_idx SHALL increment.
REQ-020 On an output handshake with out_last, the FSM SHALL reload from the next window if one is available (REQ-026); otherwise it SHALL return to IDLE.
REQ-021 out_idx SHALL never exceed DATA_W-1 and never wraps within a window.
REQ-022 Sample bits SHALL be emitted unmodified; no sign extension and no arithmetic are performed in this block.
REQ-023 An input handshake SHALL occur only when in_ready is high; in_data is ignored otherwise.

Reset
REQ-024 While rst is high: state=IDLE, out_valid=0, in_ready=0, out_idx=0, out_bits=0, and the shadow buffer is empty.
REQ-025 rst asserted mid-window SHALL discard that window and any buffered window, with no residual planes after release; in_ready SHALL be 1 on the first cycle after release.

Configuration
REQ-026 Macro DA_DOUBLE_BUF_EN SHALL add a one-window shadow register:
- in_ready = !shadow_full in both states.
- On an out_last handshake with the shadow full, the shadow SHALL move to the working registers, out_idx SHALL become 0, and the FSM SHALL stay in SHIFT with no bubble.
- An input handshake on the same cycle as an out_last handshake with the shadow empty SHALL bypass directly into the working registers.
REQ-027 Without DA_DOUBLE_BUF_EN, in_ready SHALL be 1 only in IDLE. Sustained throughput is then one window per DATA_W+1 cycles.

Structure
REQ-028 Package da_pkg SHALL hold:
- the state enum (IDLE, SHIFT);
- the DATA_W and KERNEL_H defaults;
- the out_idx width localparam.
REQ-029 Sub-module da_shift_bank SHALL hold KERNEL_H lanes of DATA_W bits, with parallel load, shift-right enable, and an LSB tap output; it is instantiated once for the working registers.

Verification
REQ-030 Taps 1..7 (tap k = k+1), out_ready=1 -> planes 0x55, 0x66, 0x78, then 0x00 x5; out_first at idx 0; out_last at idx 7.
REQ-031 All taps 0x80 -> planes 0..6 = 0x00; plane 7 = 0x7F with out_last=1.
REQ-032 out_ready low for 3 cycles at idx 2 -> out_bits=0x78 and out_idx=2 stable for those cycles; idx 3 follows the handshake.
REQ-033 Two windows offered back-to-back with out_ready=1 -> with DA_DOUBLE_BUF_EN, 16 consecutive valid cycles; without it, exactly one out_valid=0 cycle between the windows.
REQ-034 rst pulsed at idx 4 -> out_valid=0 during reset and after release; in_ready=1 on the first cycle after release; the next window starts at idx 0.
REQ-035 DA_DOUBLE_BUF_EN, with the shadow empty and an input handshake coinciding with the out_last handshake -> the next cycle shows the new window's idx 0 plane and in_ready=1.
